// File: rtl/s_machine_pkg.sv
// Shared S-Machine definitions: datapath sizes, opcodes, instruction field
// positions, writeback FSM states and per-opcode commit ownership.
package s_machine_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;
    localparam int PSW_W    = 3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int MASK_MSB = 10;
    localparam int MASK_LSB = 8;
    localparam int RA_MSB   = 5;
    localparam int RA_LSB   = 3;
    localparam int RB_MSB   = 2;
    localparam int RB_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } wb_state_e;

    // ALU result ports are only meaningful for the opcodes that own them.
    function automatic logic writes_ra(input logic [3:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR, OP_EXCH: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic writes_rb(input logic [3:0] op);
        logic w;
        case (op)
            OP_MOV, OP_EXCH: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic writes_psw(input logic [3:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR,
            OP_CMP, OP_SET, OP_CLR: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/reg_writeback_stage_if.sv
// Instruction handshake, ALU connection and debug read port of the
// writeback stage; slave is the stage, master is its environment.
interface reg_writeback_stage_if;
    import s_machine_pkg::*;

    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic              inst_ready;
    logic              done;
    logic [DATA_W-1:0] alu_inst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_z;
    logic              alu_n;
    logic              alu_c;
    logic [DATA_W-1:0] res_a;
    logic [DATA_W-1:0] res_b;
    logic              res_z;
    logic              res_n;
    logic              res_c;
    logic [PSW_W-1:0]  psw;
    logic [IDX_W-1:0]  dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output inst_valid, inst, res_a, res_b, res_z, res_n, res_c, dbg_sel,
        input  inst_ready, done, alu_inst, alu_a, alu_b, alu_z, alu_n, alu_c,
               psw, dbg_data
    );

    modport slave (
        input  inst_valid, inst, res_a, res_b, res_z, res_n, res_c, dbg_sel,
        output inst_ready, done, alu_inst, alu_a, alu_b, alu_z, alu_n, alu_c,
               psw, dbg_data
    );

endinterface

// File: rtl/reg_file_8x16.sv
// Eight 16-bit registers: two async read ports, two sync write ports with
// port B taking priority on an address collision, and a debug read port.
module reg_file_8x16
    import s_machine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we_a,
    input  logic [IDX_W-1:0]  waddr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic [IDX_W-1:0]  waddr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [IDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    assign rdata_a  = regs_r[raddr_a];
    assign rdata_b  = regs_r[raddr_b];
    assign dbg_data = regs_r[dbg_sel];

    // Register storage; EXCH with RA==RB relies on port B overriding port A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_b && (waddr_b == IDX_W'(i))) begin
                    regs_r[i] <= wdata_b;
                end else if (we_a && (waddr_a == IDX_W'(i))) begin
                    regs_r[i] <= wdata_a;
                end
            end
        end
    end

endmodule

// File: rtl/reg_writeback_stage.sv
// Sequences one instruction through the ALU (operands, then opcode) and
// commits the ALU results to the register file and PSW per opcode.
module reg_writeback_stage
    import s_machine_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    reg_writeback_stage_if.slave bus
);

    wb_state_e         state_r;
    wb_state_e         state_s;
    logic [DATA_W-1:0] inst_r;
    logic [DATA_W-1:0] alu_inst_r;
    logic [IDX_W-1:0]  ra_r;
    logic [IDX_W-1:0]  rb_r;
    logic [PSW_W-1:0]  psw_r;
    logic              done_r;
    logic              inst_ready_r;
    logic [3:0]        op_s;
    logic [IDX_W-1:0]  raddr_a_s;
    logic [IDX_W-1:0]  raddr_b_s;
    logic [DATA_W-1:0] rdata_a_s;
    logic [DATA_W-1:0] rdata_b_s;
    logic              we_a_s;
    logic              we_b_s;
    logic              psw_we_s;

    assign op_s = inst_r[OP_MSB:OP_LSB];

    // Next-state logic: fixed four-cycle walk once an instruction is taken.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.inst_valid) begin
                    state_s = ST_OPER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OPER: state_s = ST_EXEC;
            ST_EXEC: state_s = ST_WB;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand addressing and commit strobes derived from the current state.
    always_comb begin
        we_a_s    = 1'b0;
        we_b_s    = 1'b0;
        psw_we_s  = 1'b0;
        raddr_a_s = 3'd0;
        raddr_b_s = 3'd0;
        if (state_r == ST_WB) begin
            we_a_s   = writes_ra(op_s);
            we_b_s   = writes_rb(op_s);
            psw_we_s = writes_psw(op_s);
        end else begin
            we_a_s   = 1'b0;
            we_b_s   = 1'b0;
            psw_we_s = 1'b0;
        end
        if (state_r != ST_IDLE) begin
            raddr_a_s = ra_r;
            raddr_b_s = rb_r;
        end else begin
            raddr_a_s = 3'd0;
            raddr_b_s = 3'd0;
        end
    end

    // FSM state, instruction latch, PSW and registered handshake/ALU outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            inst_r       <= 16'h0000;
            ra_r         <= 3'd0;
            rb_r         <= 3'd0;
            psw_r        <= 3'b000;
            done_r       <= 1'b0;
            inst_ready_r <= 1'b1;
            alu_inst_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && bus.inst_valid) begin
                inst_r <= bus.inst;
                ra_r   <= bus.inst[RA_MSB:RA_LSB];
                rb_r   <= bus.inst[RB_MSB:RB_LSB];
            end
            if (psw_we_s) begin
                psw_r <= {bus.res_z, bus.res_n, bus.res_c};
            end
            done_r       <= (state_s == ST_WB);
            inst_ready_r <= (state_s == ST_IDLE);
            // Dropping to NOP outside EXEC gives the ALU a fresh edge every time.
            alu_inst_r   <= (state_s == ST_EXEC) ? inst_r : {OP_NOP, 12'h000};
        end
    end

    reg_file_8x16 u_reg_file (
        .clk      (clk),
        .rst_n    (reset_n),
        .raddr_a  (raddr_a_s),
        .rdata_a  (rdata_a_s),
        .raddr_b  (raddr_b_s),
        .rdata_b  (rdata_b_s),
        .we_a     (we_a_s),
        .waddr_a  (ra_r),
        .wdata_a  (bus.res_a),
        .we_b     (we_b_s),
        .waddr_b  (rb_r),
        .wdata_b  (bus.res_b),
        .dbg_sel  (bus.dbg_sel),
        .dbg_data (bus.dbg_data)
    );

    assign bus.inst_ready = inst_ready_r;
    assign bus.done       = done_r;
    assign bus.alu_inst   = alu_inst_r;
    assign bus.alu_a      = rdata_a_s;
    assign bus.alu_b      = rdata_b_s;
    assign bus.alu_z      = psw_r[2];
    assign bus.alu_n      = psw_r[1];
    assign bus.alu_c      = psw_r[0];
    assign bus.psw        = psw_r;

endmodule
